// File: rtl/rv_dpram.sv
// Simple two-port RAM: one synchronous write port and one registered read port.
// The read register holds its last value whenever rd_en is low.
module rv_dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = wr_addr ^ rd_addr;

endmodule

// File: rtl/rv_stream_fifo.sv
// Ready/valid stream FIFO built around rv_dpram; the RAM read register doubles
// as the first-word-fall-through output stage, so count = RAM entries + out_valid.
module rv_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] MEM_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          wr_fire;
  logic          rd_issue;

  assign in_ready = (mem_cnt < MEM_FULL);
  assign wr_fire  = in_valid && in_ready;
  // mem_cnt excludes the word being written this edge, so a read never races its write
  assign rd_issue = (mem_cnt != '0) && (!out_valid || out_ready);
  assign count    = mem_cnt + (AW+1)'(out_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_fire)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_issue})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (rd_issue)       out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  rv_dpram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_fire),
    .wr_addr(wr_ptr),
    .wr_data(in_data),
    .rd_en  (rd_issue),
    .rd_addr(rd_ptr),
    .rd_data(out_data)
  );

endmodule

// File: tb/tb_rv_stream_fifo.sv
// Self-checking bench for rv_stream_fifo (WIDTH=8, DEPTH=4): a queue-based model
// of held words is compared against the DUT every cycle, plus directed literal checks.
module tb_rv_stream_fifo;

  localparam int W = 8;
  localparam int D = 4;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  // Model: all held words in order, and whether the oldest sits in the output stage.
  logic [7:0] mq[$];
  bit         mov;
  logic [7:0] sent[$];
  logic [7:0] dut_got[$];

  rv_stream_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ram_n();
    return mq.size() - (mov ? 1 : 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mov = 1'b0;
    end else begin
      int rn;
      bit acc, iss, pop;
      rn  = ram_n();
      acc = in_valid && (rn < D);
      iss = (rn > 0) && (!mov || out_ready);
      pop = mov && out_ready;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(in_data);
        sent.push_back(in_data);
      end
      mov = iss ? 1'b1 : (pop ? 1'b0 : mov);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(ram_n() < D));
      chk("out_valid", 32'(out_valid), 32'(mov));
      chk("count", 32'(count), 32'(mq.size()));
      if (mov) chk("out_data", 32'(out_data), 32'(mq[0]));
      if (out_valid && out_ready) dut_got.push_back(out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic drain();
    drive(1'b0, 8'h00, 1'b1);
    repeat (12) step();
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
  endtask

  task automatic cmp_seq(input string name, input bq_t exp);
    chk({name, "_len"}, 32'(dut_got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_got.size(); i++) begin
      $display("%s word %0d: got %02h expected %02h", name, i, dut_got[i], exp[i]);
      chk({name, "_word"}, 32'(dut_got[i]), 32'(exp[i]));
    end
    dut_got.delete();
    sent.delete();
  endtask

  initial begin
    bq_t exp;
    int  n;

    #1 rst = 1'b1;
    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    #9 rst = 1'b0;

    // Single word latency and stall hold
    drive(1'b1, 8'hA5, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_count", 32'(count), 32'd1);
      if (k < 5) step();
    end
    drain();
    exp = '{8'hA5};
    cmp_seq("single", exp);

    // Fill to DEPTH+1 with the consumer stalled
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
    end
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd5);
    chk("fill_accepted", 32'(sent.size()), 32'd5);
    drain();
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    cmp_seq("fill", exp);

    // Full throughput streaming
    for (int k = 0; k < 12; k++) begin
      drive(k < 10, 8'(8'h10 + k), 1'b1);
      step();
      if (k >= 1 && k <= 10) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data", 32'(out_data), 32'(8'h10 + k - 1));
      end
    end
    drain();
    exp = '{};
    for (int i = 0; i < 10; i++) exp.push_back(8'(8'h10 + i));
    cmp_seq("stream", exp);

    // Random traffic, 200 words
    n = 0;
    while (sent.size() < 200 && n < 4000) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step();
      if (count > 3'd5) chk("random_count_max", 32'(count), 32'd5);
      n++;
    end
    chk("random_accepted", 32'(sent.size()), 32'd200);
    in_valid = 1'b0;
    drain();
    exp = sent;
    cmp_seq("random", exp);

    // Asynchronous reset with words held
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b0);
      step();
    end
    in_valid = 1'b0;
    chk("pre_reset_count", 32'(count), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    dut_got.delete();
    sent.delete();
    drive(1'b1, 8'h7E, 1'b0);
    step();
    in_valid = 1'b0;
    chk("post_reset_early", 32'(out_valid), 32'd0);
    step();
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    chk("post_reset_data", 32'(out_data), 32'h7E);
    drain();
    exp = '{8'h7E};
    cmp_seq("post_reset", exp);

    // Pointer wrap with occasional stalls
    n = 0;
    while (sent.size() < 9 && n < 200) begin
      drive(1'b1, 8'(8'h20 + sent.size()), (n % 3) != 0);
      step();
      n++;
    end
    chk("wrap_accepted", 32'(sent.size()), 32'd9);
    drain();
    exp = '{};
    for (int i = 0; i < 9; i++) exp.push_back(8'(8'h20 + i));
    cmp_seq("wrap", exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
